// File: rtl/decode_buffer_stage_if.sv
// Port bundle for the decode buffer stage: upstream fetch handshake, downstream
// handshake, register-file read port and decoded head fields.
interface decode_buffer_stage_if #(
  parameter int ADDR_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_REGISTERS     = 32,
  parameter int DEPTH             = 4
);
  localparam int RW = $clog2(NUM_REGISTERS);
  localparam int OW = $clog2(DEPTH + 1);

  logic                         prev_done;
  logic                         stall_prev;
  logic [ADDR_WIDTH-1:0]        program_count;
  logic [INSTRUCTION_WIDTH-1:0] instruction_data;
  logic                         instruction_data_valid;
  logic                         flush;
  logic                         done_next;
  logic                         next_stall;
  logic [RW-1:0]                register_read_1;
  logic [RW-1:0]                register_read_2;
  logic [DATA_WIDTH-1:0]        register_read_1_data;
  logic [DATA_WIDTH-1:0]        register_read_2_data;
  logic                         register_read_1_contended;
  logic                         register_read_2_contended;
  logic [ADDR_WIDTH-1:0]        program_count_out;
  logic [INSTRUCTION_WIDTH-1:0] instruction_out;
  logic                         instruction_valid_out;
  logic [DATA_WIDTH-1:0]        register_1_data;
  logic [DATA_WIDTH-1:0]        register_2_data;
  logic                         register_1_data_valid;
  logic                         register_2_data_valid;
  logic [RW-1:0]                write_register;
  logic                         write_register_valid;
  logic                         opcode_valid;
  logic [OW-1:0]                occupancy;

  modport slave (
    input  prev_done, program_count, instruction_data, instruction_data_valid, flush,
           next_stall, register_read_1_data, register_read_2_data,
           register_read_1_contended, register_read_2_contended,
    output stall_prev, done_next, register_read_1, register_read_2,
           program_count_out, instruction_out, instruction_valid_out,
           register_1_data, register_2_data, register_1_data_valid, register_2_data_valid,
           write_register, write_register_valid, opcode_valid, occupancy
  );

  modport master (
    output prev_done, program_count, instruction_data, instruction_data_valid, flush,
           next_stall, register_read_1_data, register_read_2_data,
           register_read_1_contended, register_read_2_contended,
    input  stall_prev, done_next, register_read_1, register_read_2,
           program_count_out, instruction_out, instruction_valid_out,
           register_1_data, register_2_data, register_1_data_valid, register_2_data_valid,
           write_register, write_register_valid, opcode_valid, occupancy
  );
endinterface

// File: rtl/decode_buffer_stage.sv
// Instruction buffer between fetch and decode: circular FIFO whose head entry is
// decoded for register usage and held back while any source operand is contended.
module decode_buffer_stage #(
  parameter int DEPTH             = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_REGISTERS     = 32
) (
  input logic                  clk,
  input logic                  rst,
  decode_buffer_stage_if.slave bus
);
  localparam int RW = $clog2(NUM_REGISTERS);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic                         valid;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ;
  entry_t        head;
  logic          empty, full, head_ok, hazard;
  logic          transfer_in, transfer_out;
  logic          use1, use2, use_rd, op_known;

  assign head  = mem[rd_ptr];
  assign empty = (occ == '0);
  assign full  = (occ == OW'(DEPTH));

  // A full buffer still accepts when the head leaves this same cycle.
  assign bus.stall_prev = full && !transfer_out && !bus.flush;
  assign bus.done_next  = !empty && !hazard && !bus.flush;
  assign transfer_in    = bus.prev_done && !bus.stall_prev;
  assign transfer_out   = bus.done_next && !bus.next_stall;

  assign head_ok = !empty && head.valid;

  always_comb begin
    use1     = 1'b0;
    use2     = 1'b0;
    use_rd   = 1'b0;
    op_known = 1'b0;
    if (head_ok) begin
      op_known = 1'b1;
      case (head.instr[6:0])
        7'b0110011: begin use1 = 1'b1; use2 = 1'b1; use_rd = 1'b1; end
        7'b0010011,
        7'b0000011,
        7'b1100111: begin use1 = 1'b1; use_rd = 1'b1; end
        7'b0100011,
        7'b1100011: begin use1 = 1'b1; use2 = 1'b1; end
        7'b1101111,
        7'b0110111,
        7'b0010111: use_rd = 1'b1;
        7'b1110011: ;
        default:    op_known = 1'b0;
      endcase
    end
  end

  assign hazard = (use1 && bus.register_read_1_contended) ||
                  (use2 && bus.register_read_2_contended);

  assign bus.register_read_1       = use1 ? RW'(head.instr[19:15]) : '0;
  assign bus.register_read_2       = use2 ? RW'(head.instr[24:20]) : '0;
  assign bus.register_1_data       = DATA_WIDTH'(bus.register_read_1_data);
  assign bus.register_2_data       = DATA_WIDTH'(bus.register_read_2_data);
  assign bus.register_1_data_valid = use1 && !bus.register_read_1_contended;
  assign bus.register_2_data_valid = use2 && !bus.register_read_2_contended;
  assign bus.write_register        = RW'(head.instr[11:7]);
  assign bus.write_register_valid  = use_rd;
  assign bus.opcode_valid          = op_known;
  assign bus.program_count_out     = head.pc;
  assign bus.instruction_out       = head.instr;
  assign bus.instruction_valid_out = head_ok;
  assign bus.occupancy             = occ;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (transfer_in)  wr_ptr <= wr_ptr + 1'b1;
      if (transfer_out) rd_ptr <= rd_ptr + 1'b1;
      case ({transfer_in, transfer_out})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (transfer_in && !bus.flush && !rst)
      mem[wr_ptr] <= '{pc: bus.program_count, instr: bus.instruction_data,
                       valid: bus.instruction_data_valid};
  end
endmodule
